key_cmd_mapper: RTL and testbench

- Converts the raw PS/2 scan-code byte stream from the keyboard decoder into a parametrised vector of command lines, for example the stopwatch start/stop/reset buttons.
- Tracks make, break (F0) and extended (E0) prefixes and matches codes against a parameter table.
- Drives commands in pulse, level or exclusive mode.
- Sits between the keyboard decoder and any control consumer; replaces hand-written per-key case logic.

---
 rtl/key_cmd_if.sv | 25 ++
 rtl/key_cmd_mapper.sv | 158 +++++++++++++++
 tb/tb_key_cmd_mapper.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_cmd_if.sv
// Scan-code in / command out bundle between the keyboard decoder and the mapper.
interface key_cmd_if #(
  parameter int unsigned NUM_CMDS = 4,
  parameter int unsigned IDX_W    = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
);
  logic                key_ready;
  logic [7:0]          key;
  logic [NUM_CMDS-1:0] cmd;
  logic                cmd_valid;
  logic [IDX_W-1:0]    cmd_idx;
  logic                miss;
  logic                err;

  // Keyboard-decoder side: supplies bytes, observes commands.
  modport master (
    output key_ready, key,
    input  cmd, cmd_valid, cmd_idx, miss, err
  );

  // Mapper side: consumes bytes, drives commands.
  modport slave (
    input  key_ready, key,
    output cmd, cmd_valid, cmd_idx, miss, err
  );
endinterface

// File: rtl/key_cmd_mapper.sv
// Maps PS/2 scan-code bytes (with E0/F0 prefixes) onto a table-driven command vector.
module key_cmd_mapper #(
  parameter int unsigned             NUM_CMDS       = 4,
  parameter logic [8*NUM_CMDS-1:0]   CODE_TABLE     = {8'h75, 8'h2D, 8'h4D, 8'h1B},
  parameter logic [NUM_CMDS-1:0]     EXT_MASK       = 4'b1000,
  parameter int unsigned             MODE           = 2,
  parameter int unsigned             PREFIX_TIMEOUT = 1000000
) (
  input logic       clk,
  input logic       reset,
  key_cmd_if.slave  bus
);

  localparam int unsigned IDX_W      = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;
  localparam int unsigned CNT_W      = 24;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);
  localparam logic [7:0]  BYTE_EXT   = 8'hE0;
  localparam logic [7:0]  BYTE_BRK   = 8'hF0;
  localparam int unsigned MODE_PULSE = 0;
  localparam int unsigned MODE_LEVEL = 1;
  localparam int unsigned MODE_EXCL  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_CMDS-1:0] cmd_q, cmd_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [IDX_W-1:0]    cmd_idx_q, cmd_idx_d;
  logic                miss_q, miss_d;
  logic                err_q, err_d;

  logic                make_c;
  logic                brk_c;
  logic                ext_c;
  logic                prefix_err_c;
  logic                hit_c;
  logic [IDX_W-1:0]    hit_idx_c;
  logic [NUM_CMDS-1:0] hit_onehot_c;

  assign ext_c = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);

  // Table lookup of the current byte; lowest matching index wins.
  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    for (int unsigned i = 0; i < NUM_CMDS; i++) begin
      if (!hit_c && (bus.key == CODE_TABLE[8*i +: 8]) && (ext_c == EXT_MASK[i])) begin
        hit_c     = 1'b1;
        hit_idx_c = IDX_W'(i);
      end
    end
    hit_onehot_c = NUM_CMDS'(1) << hit_idx_c;
  end

  // Prefix tracking and timeout; flags make/break events and protocol errors.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    make_c       = 1'b0;
    brk_c        = 1'b0;
    prefix_err_c = 1'b0;

    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (bus.key_ready) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d        = '0;
      prefix_err_c = 1'b1;
      state_d      = ST_IDLE;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (bus.key_ready) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.key == BYTE_EXT)      state_d = ST_EXT;
          else if (bus.key == BYTE_BRK) state_d = ST_BRK;
          else                          make_c  = 1'b1;
        end
        ST_EXT: begin
          if (bus.key == BYTE_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (bus.key != BYTE_EXT) begin
            make_c  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if ((bus.key == BYTE_EXT) || (bus.key == BYTE_BRK)) prefix_err_c = 1'b1;
          else                                                brk_c        = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Command vector and status pulses for the current event.
  always_comb begin
    cmd_d       = (MODE == MODE_PULSE) ? '0 : cmd_q;
    cmd_valid_d = 1'b0;
    cmd_idx_d   = cmd_idx_q;
    miss_d      = 1'b0;
    err_d       = prefix_err_c;

    if (make_c) begin
      if (hit_c) begin
        cmd_valid_d = 1'b1;
        cmd_idx_d   = hit_idx_c;
        if (MODE == MODE_LEVEL)      cmd_d = cmd_q | hit_onehot_c;
        else if (MODE == MODE_EXCL)  cmd_d = hit_onehot_c;
        else                         cmd_d = hit_onehot_c;
      end else begin
        miss_d = 1'b1;
      end
    end

    if (brk_c && hit_c && (MODE == MODE_LEVEL)) begin
      cmd_d = cmd_q & ~hit_onehot_c;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_idx_q   <= '0;
      miss_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_idx_q   <= cmd_idx_d;
      miss_q      <= miss_d;
      err_q       <= err_d;
    end
  end

  assign bus.cmd       = cmd_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_idx   = cmd_idx_q;
  assign bus.miss      = miss_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_key_cmd_mapper.sv
// Bench for key_cmd_mapper: three instances (pulse, level, exclusive) share one byte stream.
module tb_key_cmd_mapper;

  localparam int TO = 20;

  logic       clk;
  logic       reset;
  logic       key_ready;
  logic [7:0] key;

  int checks = 0;
  int errors = 0;

  key_cmd_if #(.NUM_CMDS(4)) bus0 ();
  key_cmd_if #(.NUM_CMDS(4)) bus1 ();
  key_cmd_if #(.NUM_CMDS(4)) bus2 ();

  assign bus0.key_ready = key_ready;
  assign bus0.key       = key;
  assign bus1.key_ready = key_ready;
  assign bus1.key       = key;
  assign bus2.key_ready = key_ready;
  assign bus2.key       = key;

  key_cmd_mapper #(.MODE(0), .PREFIX_TIMEOUT(TO)) dut_pulse (.clk(clk), .reset(reset), .bus(bus0.slave));
  key_cmd_mapper #(.MODE(1), .PREFIX_TIMEOUT(TO)) dut_level (.clk(clk), .reset(reset), .bus(bus1.slave));
  key_cmd_mapper #(.MODE(2), .PREFIX_TIMEOUT(TO)) dut_excl  (.clk(clk), .reset(reset), .bus(bus2.slave));

  logic [8:0] act [3];
  assign act[0] = {bus0.cmd, bus0.cmd_valid, bus0.cmd_idx, bus0.miss, bus0.err};
  assign act[1] = {bus1.cmd, bus1.cmd_valid, bus1.cmd_idx, bus1.miss, bus1.err};
  assign act[2] = {bus2.cmd, bus2.cmd_valid, bus2.cmd_idx, bus2.miss, bus2.err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: prefix flags plus an idle-age counter, one expected cmd per mode.
  logic [7:0] tbl [4] = '{8'h1B, 8'h4D, 8'h2D, 8'h75};
  bit         tbl_ext [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  bit         pend_ext, pend_brk;
  int         age;
  logic [3:0] exp_cmd [3];
  logic       exp_valid, exp_miss, exp_err;
  logic [1:0] exp_idx;

  function automatic logic [8:0] exp_vec(input int m);
    return {exp_cmd[m], exp_valid, exp_idx, exp_miss, exp_err};
  endfunction

  task automatic model_step(input logic r, input logic kr, input logic [7:0] k);
    bit ev, is_brk, ext, hit;
    int idx;
    logic [3:0] oh;
    ev = 0; is_brk = 0; ext = 0; hit = 0; idx = 0;
    if (!r) begin
      pend_ext = 0; pend_brk = 0; age = 0;
      for (int m = 0; m < 3; m++) exp_cmd[m] = 4'b0;
      exp_valid = 0; exp_idx = 2'd0; exp_miss = 0; exp_err = 0;
    end else begin
      exp_valid = 0; exp_miss = 0; exp_err = 0;
      exp_cmd[0] = 4'b0;
      if (kr) begin
        age = 0;
        if (k == 8'hE0 || k == 8'hF0) begin
          if (pend_brk) begin
            exp_err = 1; pend_ext = 0; pend_brk = 0;
          end else if (k == 8'hF0) begin
            pend_brk = 1;
          end else begin
            pend_ext = 1;
          end
        end else begin
          ev = 1; ext = pend_ext; is_brk = pend_brk;
          pend_ext = 0; pend_brk = 0;
        end
      end else if (pend_ext || pend_brk) begin
        if (age == TO - 1) begin
          exp_err = 1; pend_ext = 0; pend_brk = 0; age = 0;
        end else begin
          age++;
        end
      end
      if (ev) begin
        for (int i = 0; i < 4; i++)
          if (!hit && k == tbl[i] && ext == tbl_ext[i]) begin hit = 1; idx = i; end
        oh = 4'(1) << idx;
        if (!is_brk) begin
          if (hit) begin
            exp_valid  = 1;
            exp_idx    = 2'(idx);
            exp_cmd[0] = oh;
            exp_cmd[1] = exp_cmd[1] | oh;
            exp_cmd[2] = oh;
          end else begin
            exp_miss = 1;
          end
        end else if (hit) begin
          exp_cmd[1] = exp_cmd[1] & ~oh;
        end
      end
    end
  endtask

  task automatic tick(input logic r, input logic kr, input logic [7:0] k);
    reset = r; key_ready = kr; key = k;
    @(posedge clk);
    model_step(r, kr, k);
    #1;
    key_ready = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      tick(1'b0, 1'b1, 8'h1B);
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (act[m] !== 9'b0) begin
          errors++;
          $display("FAIL reset step %0d mode %0d: got %b expected %b", s, m, act[m], 9'b0);
        end
      end
    end
    tick(1'b1, 1'b1, 8'h1B);
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (act[m] !== exp_vec(m)) begin
        errors++;
        $display("FAIL reset_first_make mode %0d: got %b expected %b", m, act[m], exp_vec(m));
      end
    end
    checks++;
    if ({bus2.cmd, bus2.cmd_valid, bus2.cmd_idx} !== {4'b0001, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL reset_latency: got cmd=%b valid=%b idx=%0d expected 0001 1 0", bus2.cmd, bus2.cmd_valid, bus2.cmd_idx);
    end
    tick(1'b1, 1'b0, 8'h00);
    checks++;
    if ({bus2.cmd, bus2.cmd_valid} !== {4'b0001, 1'b0}) begin
      errors++;
      $display("FAIL valid_one_cycle: got cmd=%b valid=%b expected 0001 0", bus2.cmd, bus2.cmd_valid);
    end
  endtask

  task automatic test_exclusive();
    logic [7:0] seq  [5] = '{8'h1B, 8'h4D, 8'hF0, 8'h4D, 8'h2D};
    logic [3:0] want [5] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    tick(1'b0, 1'b0, 8'h00);
    for (int s = 0; s < 5; s++) begin
      tick(1'b1, 1'b1, seq[s]);
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (act[m] !== exp_vec(m)) begin
          errors++;
          $display("FAIL exclusive step %0d mode %0d: got %b expected %b", s, m, act[m], exp_vec(m));
        end
      end
      checks++;
      if (bus2.cmd !== want[s]) begin
        errors++;
        $display("FAIL exclusive_cmd step %0d: got %b expected %b", s, bus2.cmd, want[s]);
      end
    end
  endtask

  task automatic test_level();
    logic [7:0] seq  [6] = '{8'h1B, 8'h4D, 8'hF0, 8'h1B, 8'hF0, 8'h4D};
    logic [4:0] want [6] = '{5'b0001_1, 5'b0011_1, 5'b0011_0, 5'b0010_0, 5'b0010_0, 5'b0000_0};
    tick(1'b0, 1'b0, 8'h00);
    for (int s = 0; s < 6; s++) begin
      tick(1'b1, 1'b1, seq[s]);
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (act[m] !== exp_vec(m)) begin
          errors++;
          $display("FAIL level step %0d mode %0d: got %b expected %b", s, m, act[m], exp_vec(m));
        end
      end
      checks++;
      if ({bus1.cmd, bus1.cmd_valid} !== want[s]) begin
        errors++;
        $display("FAIL level_cmd step %0d: got %b expected %b", s, {bus1.cmd, bus1.cmd_valid}, want[s]);
      end
    end
  endtask

  task automatic test_extended();
    logic [7:0] seq  [6] = '{8'hE0, 8'h75, 8'h75, 8'hE0, 8'hF0, 8'h75};
    logic [5:0] want [6] = '{6'b0000_0_0, 6'b1000_1_0, 6'b0000_0_1, 6'b0000_0_0, 6'b0000_0_0, 6'b0000_0_0};
    tick(1'b0, 1'b0, 8'h00);
    for (int s = 0; s < 6; s++) begin
      tick(1'b1, 1'b1, seq[s]);
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (act[m] !== exp_vec(m)) begin
          errors++;
          $display("FAIL extended step %0d mode %0d: got %b expected %b", s, m, act[m], exp_vec(m));
        end
      end
      checks++;
      if ({bus0.cmd, bus0.cmd_valid, bus0.miss} !== want[s] || (s == 1 && bus0.cmd_idx !== 2'd3)) begin
        errors++;
        $display("FAIL extended_pulse step %0d: got %b idx=%0d expected %b", s,
                 {bus0.cmd, bus0.cmd_valid, bus0.miss}, bus0.cmd_idx, want[s]);
      end
    end
  endtask

  task automatic test_errors();
    logic [7:0] seq  [3] = '{8'hF0, 8'hF0, 8'h1B};
    logic [5:0] want [3] = '{6'b0000_0_0, 6'b0000_1_0, 6'b0001_0_1};
    tick(1'b0, 1'b0, 8'h00);
    for (int s = 0; s < 3; s++) begin
      tick(1'b1, 1'b1, seq[s]);
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (act[m] !== exp_vec(m)) begin
          errors++;
          $display("FAIL errors step %0d mode %0d: got %b expected %b", s, m, act[m], exp_vec(m));
        end
      end
      checks++;
      if ({bus2.cmd, bus2.err, bus2.cmd_valid} !== want[s]) begin
        errors++;
        $display("FAIL double_break step %0d: got %b expected %b", s, {bus2.cmd, bus2.err, bus2.cmd_valid}, want[s]);
      end
    end
  endtask

  task automatic test_timeout();
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'hE0);
    for (int s = 1; s <= TO; s++) begin
      tick(1'b1, 1'b0, 8'h00);
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (act[m] !== exp_vec(m)) begin
          errors++;
          $display("FAIL timeout idle %0d mode %0d: got %b expected %b", s, m, act[m], exp_vec(m));
        end
      end
      checks++;
      if (bus0.err !== (s == TO)) begin
        errors++;
        $display("FAIL timeout_err idle %0d: got %b expected %b", s, bus0.err, (s == TO));
      end
    end
    tick(1'b1, 1'b1, 8'h75);
    checks++;
    if ({bus0.cmd, bus0.miss, bus0.err} !== {4'b0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL timeout_then_plain: got cmd=%b miss=%b err=%b expected 0000 1 0", bus0.cmd, bus0.miss, bus0.err);
    end
    // Byte arriving on the terminal-count cycle beats the timeout.
    tick(1'b1, 1'b1, 8'hE0);
    for (int s = 1; s < TO; s++) tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'h75);
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (act[m] !== exp_vec(m)) begin
        errors++;
        $display("FAIL timeout_edge mode %0d: got %b expected %b", m, act[m], exp_vec(m));
      end
    end
    checks++;
    if ({bus0.cmd, bus0.cmd_valid, bus0.err} !== {4'b1000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL key_beats_timeout: got cmd=%b valid=%b err=%b expected 1000 1 0", bus0.cmd, bus0.cmd_valid, bus0.err);
    end
  endtask

  task automatic test_reset_mid_prefix();
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'hF0);
    tick(1'b0, 1'b1, 8'h1B);
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (act[m] !== 9'b0) begin
        errors++;
        $display("FAIL reset_mid_prefix mode %0d: got %b expected %b", m, act[m], 9'b0);
      end
    end
    tick(1'b1, 1'b1, 8'h1B);
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (act[m] !== exp_vec(m)) begin
        errors++;
        $display("FAIL after_reset_make mode %0d: got %b expected %b", m, act[m], exp_vec(m));
      end
    end
    checks++;
    if ({bus2.cmd, bus2.cmd_valid, bus1.cmd} !== {4'b0001, 1'b1, 4'b0001}) begin
      errors++;
      $display("FAIL prefix_cleared: got excl=%b valid=%b level=%b expected 0001 1 0001", bus2.cmd, bus2.cmd_valid, bus1.cmd);
    end
  endtask

  task automatic test_random();
    int burst = 0;
    int r;
    logic [7:0] k;
    tick(1'b0, 1'b0, 8'h00);
    for (int s = 0; s < 800; s++) begin
      if (burst > 0) begin
        burst--;
        tick(1'b1, 1'b0, 8'h00);
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 2) begin
          tick(1'b0, ($urandom_range(0, 1) == 1), 8'h1B);
        end else if (r < 8) begin
          burst = int'($urandom_range(TO - 2, TO + 2));
          tick(1'b1, 1'b0, 8'h00);
        end else if (r < 40) begin
          tick(1'b1, 1'b0, 8'h00);
        end else begin
          case ($urandom_range(0, 7))
            0: k = 8'hE0;
            1: k = 8'hF0;
            2: k = 8'h1B;
            3: k = 8'h4D;
            4: k = 8'h2D;
            5: k = 8'h75;
            default: k = 8'($urandom_range(0, 255));
          endcase
          tick(1'b1, 1'b1, k);
        end
      end
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (act[m] !== exp_vec(m)) begin
          errors++;
          $display("FAIL random cycle %0d mode %0d: got %b expected %b", s, m, act[m], exp_vec(m));
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    key_ready = 1'b0;
    key       = 8'h00;
    test_reset();
    test_exclusive();
    test_level();
    test_extended();
    test_errors();
    test_timeout();
    test_reset_mid_prefix();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
